lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu -- load/store unit between decode and a simple request/grant bus.
//
// Accepts one memory instruction at a time, checks alignment, issues a
// single bus request, waits for read data on loads and returns the
// lane-shifted, extended load result.
//
// State | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no access outstanding; latches a new instruction on mem_valid_ctrl
// REQ   | bus_req asserted with the latched address/strobes, waiting on gnt
// WAIT  | load granted, waiting for bus_rvalid
// DONE  | one-cycle done pulse, rdata_out valid for loads
// ERR   | one-cycle misalign pulse, no bus traffic
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   mem_valid_ctrl      instruction present from decode
//   mem_we_ctrl         0 = store, 1 = load
//   mem_size            access size/sign encoding (MEM_*)
//   addr, wdata         effective byte address, store data
//   stall               holds the pipeline while an access is outstanding
//   done, misalign      completion / misalignment pulses
//   rdata_out           extended load result (held outside DONE)
//   bus_req/we/addr/be/wdata   bus request side
//   bus_gnt, bus_rvalid, bus_rdata   bus response side
// ---------------------------------------------------------------------------
module lsu #(
  parameter int MEM_SIZE_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mem_valid_ctrl,
  input  logic                      mem_we_ctrl,
  input  logic [MEM_SIZE_WIDTH-1:0] mem_size,
  input  logic [31:0]               addr,
  input  logic [31:0]               wdata,
  output logic                      stall,
  output logic                      done,
  output logic                      misalign,
  output logic [31:0]               rdata_out,
  output logic                      bus_req,
  output logic                      bus_we,
  output logic [31:0]               bus_addr,
  output logic [3:0]                bus_be,
  output logic [31:0]               bus_wdata,
  input  logic                      bus_gnt,
  input  logic                      bus_rvalid,
  input  logic [31:0]               bus_rdata
);

  localparam logic [MEM_SIZE_WIDTH-1:0] MEM_BYTE   = MEM_SIZE_WIDTH'(0);
  localparam logic [MEM_SIZE_WIDTH-1:0] MEM_HALF   = MEM_SIZE_WIDTH'(1);
  localparam logic [MEM_SIZE_WIDTH-1:0] MEM_WORD   = MEM_SIZE_WIDTH'(2);
  localparam logic [MEM_SIZE_WIDTH-1:0] MEM_BYTE_U = MEM_SIZE_WIDTH'(4);
  localparam logic [MEM_SIZE_WIDTH-1:0] MEM_HALF_U = MEM_SIZE_WIDTH'(5);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [31:0]               addr_q;
  logic [31:0]               wdata_q;
  logic [MEM_SIZE_WIDTH-1:0] size_q;
  logic                      load_q;
  logic [31:0]               rdata_q;

  logic                      aligned;
  logic                      capture;
  logic [31:0]               rdata_shifted;
  logic [31:0]               rdata_ext;
  logic [3:0]                be_lat;
  logic [31:0]               wdata_lat;

  // Alignment of the incoming instruction; unknown sizes behave as word.
  always_comb begin
    aligned = 1'b0;
    case (mem_size)
      MEM_BYTE, MEM_BYTE_U: aligned = 1'b1;
      MEM_HALF, MEM_HALF_U: aligned = (addr[0] == 1'b0);
      default:              aligned = (addr[1:0] == 2'b00);
    endcase
  end

  // Byte strobes and lane replication from the latched access.
  always_comb begin
    be_lat    = 4'b1111;
    wdata_lat = wdata_q;
    case (size_q)
      MEM_BYTE, MEM_BYTE_U: begin
        be_lat    = 4'b0001 << addr_q[1:0];
        wdata_lat = {4{wdata_q[7:0]}};
      end
      MEM_HALF, MEM_HALF_U: begin
        be_lat    = 4'b0011 << addr_q[1:0];
        wdata_lat = {2{wdata_q[15:0]}};
      end
      default: begin
        be_lat    = 4'b1111;
        wdata_lat = wdata_q;
      end
    endcase
  end

  // Move the addressed lane to bit 0, then extend.
  always_comb begin
    rdata_shifted = bus_rdata >> {addr_q[1:0], 3'b000};
    rdata_ext     = rdata_shifted;
    case (size_q)
      MEM_BYTE:   rdata_ext = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      MEM_BYTE_U: rdata_ext = {24'h000000, rdata_shifted[7:0]};
      MEM_HALF:   rdata_ext = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      MEM_HALF_U: rdata_ext = {16'h0000, rdata_shifted[15:0]};
      default:    rdata_ext = rdata_shifted;
    endcase
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    stall     = 1'b0;
    done      = 1'b0;
    misalign  = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 32'h0;
    bus_be    = 4'b0000;
    bus_wdata = 32'h0;
    case (state)
      IDLE: begin
        if (mem_valid_ctrl) begin
          stall     = 1'b1;
          state_nxt = aligned ? REQ : ERR;
        end
      end
      REQ: begin
        stall     = 1'b1;
        bus_req   = 1'b1;
        bus_we    = ~load_q;
        bus_addr  = {addr_q[31:2], 2'b00};
        bus_be    = be_lat;
        bus_wdata = wdata_lat;
        if (bus_gnt) begin
          if (!load_q) begin
            state_nxt = DONE;
          end else if (bus_rvalid) begin
            // Grant and data in the same cycle: skip WAIT.
            capture   = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (bus_rvalid) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        misalign  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      size_q  <= '0;
      load_q  <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && mem_valid_ctrl) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        size_q  <= mem_size;
        load_q  <= mem_we_ctrl;
      end
      if (capture) begin
        rdata_q <= rdata_ext;
      end
    end
  end

  assign rdata_out = rdata_q;

endmodule
